// File: rtl/adc_sample_source_if.sv
// FIFO write-side bundle between the ADC sample source and the dual-clock capture FIFO.
interface adc_sample_source_if #(
    parameter int unsigned DATA_WIDTH = 10
) ();
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  dataValid;
    logic                  fifoFull;

    modport master (
        output dataOut,
        output dataValid,
        input  fifoFull
    );

    modport slave (
        input  dataOut,
        input  dataValid,
        output fifoFull
    );
endinterface

// File: rtl/adc_sample_source.sv
// ADC-domain sample source: live samples or test patterns, gated by a capture FSM and
// FIFO back-pressure, with sample/drop statistics for the host.
module adc_sample_source #(
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned DROP_WIDTH  = 16
) (
    input  logic                   adcClk,
    input  logic                   nReset,
    input  logic                   i_collectData,
    input  logic [1:0]             i_testMode,
    input  logic [DATA_WIDTH-1:0]  i_adcDataIn,
    input  logic                   i_clearStatus,
    adc_sample_source_if.master    io_fifo,
    output logic [COUNT_WIDTH-1:0] o_sampleCount,
    output logic [DROP_WIDTH-1:0]  o_dropCount,
    output logic                   o_overflow,
    output logic                   o_running
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StRun  = 2'd2
    } state_e;

    localparam logic [1:0] ModeLive    = 2'd0;
    localparam logic [1:0] ModeCounter = 2'd1;
    localparam logic [1:0] ModePrbs    = 2'd2;
    localparam logic [1:0] ModeTri     = 2'd3;

    localparam logic [15:0]           LfsrSeed = 16'hACE1;
    localparam logic [DATA_WIDTH-1:0] TriPeakM1 = {{(DATA_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [DATA_WIDTH-1:0] TriOne    = DATA_WIDTH'(1);
    localparam logic [DROP_WIDTH-1:0] DropMax   = {DROP_WIDTH{1'b1}};

    state_e                 r_state;
    state_e                 w_stateNext;
    logic [1:0]             r_modeReg;
    logic [DATA_WIDTH-1:0]  r_inReg;
    logic [DATA_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0]  r_tri;
    logic                   r_triUp;
    logic [15:0]            r_lfsr;
    logic [DATA_WIDTH-1:0]  r_dataOut;
    logic                   r_dataValid;
    logic [COUNT_WIDTH-1:0] r_sampleCount;
    logic [DROP_WIDTH-1:0]  r_dropCount;
    logic                   r_overflow;

    logic [DATA_WIDTH-1:0]  w_cntNext;
    logic [DATA_WIDTH-1:0]  w_triNext;
    logic                   w_triUpNext;
    logic [15:0]            w_lfsrNext;
    logic [DATA_WIDTH-1:0]  w_genValue;
    logic                   w_capture;
    logic                   w_write;
    logic                   w_drop;
    logic [DROP_WIDTH-1:0]  w_dropNext;
    logic                   w_overflowNext;

    // A RUN cycle with collectData low is the exit cycle and never writes.
    assign w_capture = (r_state == StRun) && i_collectData;
    assign w_write   = w_capture && !io_fifo.fifoFull;
    assign w_drop    = w_capture && io_fifo.fifoFull;

    always_ff @(posedge adcClk or negedge nReset) begin
        if (!nReset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            StIdle:  if (i_collectData) w_stateNext = StArm;
            StArm:   w_stateNext = StRun;
            StRun:   if (!i_collectData) w_stateNext = StIdle;
            default: w_stateNext = StIdle;
        endcase
    end

    // Generators are seeded in ARM and advance on every RUN cycle, written or not.
    always_comb begin
        w_cntNext   = r_cnt;
        w_triNext   = r_tri;
        w_triUpNext = r_triUp;
        w_lfsrNext  = r_lfsr;
        if (r_state == StArm) begin
            w_cntNext   = '0;
            w_triNext   = '0;
            w_triUpNext = 1'b1;
            w_lfsrNext  = LfsrSeed;
        end else if (r_state == StRun) begin
            w_cntNext  = r_cnt + TriOne;
            w_lfsrNext = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            if (r_triUp) begin
                w_triNext = r_tri + TriOne;
                if (r_tri == TriPeakM1) w_triUpNext = 1'b0;
            end else begin
                w_triNext = r_tri - TriOne;
                if (r_tri == TriOne) w_triUpNext = 1'b1;
            end
        end
    end

    always_comb begin
        w_genValue = r_inReg;
        unique case (r_modeReg)
            ModeLive:    w_genValue = r_inReg;
            ModeCounter: w_genValue = r_cnt;
            ModePrbs:    w_genValue = r_lfsr[DATA_WIDTH-1:0];
            ModeTri:     w_genValue = r_tri;
            default:     w_genValue = r_inReg;
        endcase
    end

    // A clear and a drop in the same cycle leave exactly that one drop recorded.
    always_comb begin
        w_dropNext     = r_dropCount;
        w_overflowNext = r_overflow;
        if (i_clearStatus) begin
            w_dropNext     = '0;
            w_overflowNext = 1'b0;
        end
        if (w_drop) begin
            if (w_dropNext != DropMax) w_dropNext = w_dropNext + DROP_WIDTH'(1);
            w_overflowNext = 1'b1;
        end
    end

    always_ff @(posedge adcClk or negedge nReset) begin
        if (!nReset) begin
            r_modeReg     <= ModeLive;
            r_inReg       <= '0;
            r_cnt         <= '0;
            r_tri         <= '0;
            r_triUp       <= 1'b1;
            r_lfsr        <= LfsrSeed;
            r_dataOut     <= '0;
            r_dataValid   <= 1'b0;
            r_sampleCount <= '0;
            r_dropCount   <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_inReg     <= i_adcDataIn;
            r_cnt       <= w_cntNext;
            r_tri       <= w_triNext;
            r_triUp     <= w_triUpNext;
            r_lfsr      <= w_lfsrNext;
            r_dataValid <= w_write;
            r_dropCount <= w_dropNext;
            r_overflow  <= w_overflowNext;
            if (r_state == StArm) begin
                r_modeReg     <= i_testMode;
                r_sampleCount <= '0;
            end else if (w_write) begin
                r_sampleCount <= r_sampleCount + COUNT_WIDTH'(1);
            end
            if (w_write) begin
                r_dataOut <= w_genValue;
            end
        end
    end

    assign io_fifo.dataOut   = r_dataOut;
    assign io_fifo.dataValid = r_dataValid;
    assign o_sampleCount     = r_sampleCount;
    assign o_dropCount       = r_dropCount;
    assign o_overflow        = r_overflow;
    assign o_running         = (r_state == StRun);

endmodule

// File: tb/tb_adc_sample_source.sv
// Directed bench for adc_sample_source: two widths side by side, scoreboard on FIFO writes.
module tb_adc_sample_source;

    logic       adcClk;
    logic       nReset;
    logic       collectData;
    logic [1:0] testMode;
    logic [9:0] adcDataIn;
    logic       fifoFull;
    logic       clearStatus;

    logic [31:0] sc10;
    logic [15:0] dc10;
    logic        ov10;
    logic        run10;
    logic [7:0]  sc4;
    logic [2:0]  dc4;
    logic        ov4;
    logic        run4;

    int checks = 0;
    int errors = 0;
    int wr;
    logic [15:0] q10[$];
    logic [15:0] q4[$];
    logic [9:0]  adc_hold = '0;

    adc_sample_source_if #(.DATA_WIDTH(10)) if10 ();
    adc_sample_source_if #(.DATA_WIDTH(4))  if4 ();

    assign if10.fifoFull = fifoFull;
    assign if4.fifoFull  = fifoFull;

    adc_sample_source #(.DATA_WIDTH(10), .COUNT_WIDTH(32), .DROP_WIDTH(16)) dut10 (
        .adcClk        (adcClk),
        .nReset        (nReset),
        .i_collectData (collectData),
        .i_testMode    (testMode),
        .i_adcDataIn   (adcDataIn),
        .i_clearStatus (clearStatus),
        .io_fifo       (if10),
        .o_sampleCount (sc10),
        .o_dropCount   (dc10),
        .o_overflow    (ov10),
        .o_running     (run10)
    );

    adc_sample_source #(.DATA_WIDTH(4), .COUNT_WIDTH(8), .DROP_WIDTH(3)) dut4 (
        .adcClk        (adcClk),
        .nReset        (nReset),
        .i_collectData (collectData),
        .i_testMode    (testMode),
        .i_adcDataIn   (adcDataIn[3:0]),
        .i_clearStatus (clearStatus),
        .io_fifo       (if4),
        .o_sampleCount (sc4),
        .o_dropCount   (dc4),
        .o_overflow    (ov4),
        .o_running     (run4)
    );

    initial begin
        adcClk = 1'b0;
        forever #5 adcClk = ~adcClk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected written value for the k-th RUN cycle after ARM, at width w.
    function automatic logic [15:0] exp_gen(input logic [1:0] mode, input int k, input int w,
                                            input logic [15:0] live);
        int mx = (1 << w) - 1;
        logic [15:0] m = 16'(mx);
        logic [15:0] l = 16'hACE1;
        int p;
        case (mode)
            2'd0: return live & m;
            2'd1: return 16'(k) & m;
            2'd2: begin
                for (int i = 0; i < k; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
                return l & m;
            end
            default: begin
                p = k % (2 * mx);
                return 16'((p <= mx) ? p : 2 * mx - p);
            end
        endcase
    endfunction

    task automatic step();
        @(posedge adcClk);
        adc_hold = adcDataIn;
        #1;
        adcDataIn = adcDataIn + 10'd1;
    endtask

    always @(negedge adcClk) begin
        if (if10.dataValid) begin
            check("wr10_pending", 32'(q10.size() > 0), 32'd1);
            if (q10.size() > 0) check("wr10_data", 32'(if10.dataOut), 32'(q10.pop_front()));
        end
        if (if4.dataValid) begin
            check("wr4_pending", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) check("wr4_data", 32'(if4.dataOut), 32'(q4.pop_front()));
        end
    end

    // One capture: fifoFull over [fs, fs+fl) and at clr_k (with clearStatus), testMode
    // altered at sw_k, asynchronous reset at rst_k. wr returns the number of writes.
    task automatic capture(input logic [1:0] mode, input int n, input int fs, input int fl,
                           input int clr_k, input int sw_k, input int rst_k, output int wr_o);
        wr_o = 0;
        testMode = mode;
        collectData = 1'b1;
        step();
        check("arm_running", 32'(run10), 32'd0);
        step();
        check("run_entry_running10", 32'(run10), 32'd1);
        check("run_entry_running4", 32'(run4), 32'd1);
        check("arm_cycle_valid", 32'(if10.dataValid), 32'd0);
        for (int k = 0; k < n; k++) begin
            if (k == rst_k) begin
                #2 nReset = 1'b0;
                #1;
                check("rst_valid10", 32'(if10.dataValid), 32'd0);
                check("rst_data10", 32'(if10.dataOut), 32'd0);
                check("rst_running10", 32'(run10), 32'd0);
                check("rst_sc10", sc10, 32'd0);
                check("rst_dc10", 32'(dc10), 32'd0);
                check("rst_ov10", 32'(ov10), 32'd0);
                check("rst_valid4", 32'(if4.dataValid), 32'd0);
                check("rst_running4", 32'(run4), 32'd0);
                q10.delete();
                q4.delete();
                collectData = 1'b0;
                fifoFull = 1'b0;
                step();
                nReset = 1'b1;
                step();
                step();
                check("post_rst_running", 32'(run10), 32'd0);
                check("post_rst_valid", 32'(if10.dataValid), 32'd0);
                wr_o = -1;
                return;
            end
            fifoFull = ((k >= fs) && (k < fs + fl)) || (k == clr_k);
            clearStatus = (k == clr_k);
            if (k == sw_k) testMode = mode + 2'd1;
            if (!fifoFull) begin
                q10.push_back(exp_gen(mode, k, 10, 16'(adc_hold)));
                q4.push_back(exp_gen(mode, k, 4, 16'(adc_hold)));
                wr_o++;
            end
            step();
            clearStatus = 1'b0;
        end
        collectData = 1'b0;
        fifoFull = 1'b0;
        step();
        check("exit_running", 32'(run10), 32'd0);
        check("exit_valid", 32'(if10.dataValid), 32'd0);
        step();
        check("idle_valid", 32'(if10.dataValid), 32'd0);
    endtask

    initial begin
        nReset = 1'b0;
        collectData = 1'b0;
        testMode = 2'd0;
        adcDataIn = '0;
        fifoFull = 1'b0;
        clearStatus = 1'b0;
        repeat (2) @(posedge adcClk);
        #1;
        check("reset_valid", 32'(if10.dataValid), 32'd0);
        check("reset_data", 32'(if10.dataOut), 32'd0);
        check("reset_running", 32'(run10), 32'd0);
        check("reset_sc", sc10, 32'd0);
        check("reset_dc", 32'(dc10), 32'd0);
        check("reset_ov", 32'(ov10), 32'd0);
        nReset = 1'b1;
        step();
        step();
        check("idle_running", 32'(run10), 32'd0);

        // Counter, long enough to wrap both widths (and the 8-bit sampleCount).
        capture(2'd1, 1030, 100000, 0, -1, -1, -1, wr);
        check("cnt_sc10", sc10, 32'(wr));
        check("cnt_sc4", 32'(sc4), 32'(wr % 256));
        check("cnt_dc10", 32'(dc10), 32'd0);
        check("cnt_ov10", 32'(ov10), 32'd0);

        // PRBS, twice, to confirm reseeding at each ARM.
        capture(2'd2, 20, 100000, 0, -1, -1, -1, wr);
        check("prbs_sc10", sc10, 32'd20);
        capture(2'd2, 20, 100000, 0, -1, -1, -1, wr);
        check("prbs_rearm_sc10", sc10, 32'd20);

        // Triangle over more than one full 4-bit period.
        capture(2'd3, 33, 100000, 0, -1, -1, -1, wr);
        check("tri_sc4", 32'(sc4), 32'd33);

        // Back-pressure: five consecutive drops.
        capture(2'd1, 20, 6, 5, -1, -1, -1, wr);
        check("bp_sc10", sc10, 32'd15);
        check("bp_dc10", 32'(dc10), 32'd5);
        check("bp_ov10", 32'(ov10), 32'd1);
        check("bp_dc4", 32'(dc4), 32'd5);

        // Clear coinciding with a drop; ARM itself must not clear.
        capture(2'd1, 10, 100000, 0, 3, -1, -1, wr);
        check("clr_drop_sc10", sc10, 32'd9);
        check("clr_drop_dc10", 32'(dc10), 32'd1);
        check("clr_drop_ov10", 32'(ov10), 32'd1);
        check("clr_drop_dc4", 32'(dc4), 32'd1);

        clearStatus = 1'b1;
        step();
        clearStatus = 1'b0;
        check("clr_idle_dc10", 32'(dc10), 32'd0);
        check("clr_idle_ov10", 32'(ov10), 32'd0);

        // Ten drops: the 3-bit counter saturates at 7.
        capture(2'd1, 14, 2, 10, -1, -1, -1, wr);
        check("sat_dc10", 32'(dc10), 32'd10);
        check("sat_dc4", 32'(dc4), 32'd7);
        check("sat_ov4", 32'(ov4), 32'd1);

        // Live path with a testMode change mid-RUN, then re-arm picks up the new mode.
        capture(2'd0, 12, 100000, 0, -1, 4, -1, wr);
        check("live_sc10", sc10, 32'd12);
        capture(2'd1, 6, 100000, 0, -1, -1, -1, wr);
        check("relock_sc10", sc10, 32'd6);

        // Asynchronous reset mid-RUN, then a clean capture.
        capture(2'd1, 10, 100000, 0, -1, -1, 5, wr);
        capture(2'd1, 5, 100000, 0, -1, -1, -1, wr);
        check("recover_sc10", sc10, 32'd5);
        check("recover_dc10", 32'(dc10), 32'd0);

        step();
        check("q10_drained", 32'(q10.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
